// File: rtl/ctl_pkt_arb.sv
// ctl_pkt_arb: two-input store-and-forward round-robin arbiter for 134-bit config packets
//   clk, rst_n         clock, asynchronous active-low reset
//   in0_* / in1_*      data, wr, ready per source (0 = DMA, 1 = local source)
//   out_data, out_wr   registered forwarded beat and its valid; out_ready = downstream accept
//   err_drop           sticky per-port drop flags
//   CTL_ARB_STATS_EN   when defined, adds grant_cnt0/grant_cnt1 forwarded-packet counters
module ctl_pkt_arb #(
  parameter int DATA_W     = 134,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_wr,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_wr,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wr,
  input  logic              out_ready,
  output logic [1:0]        err_drop
`ifdef CTL_ARB_STATS_EN
  ,
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t            state, state_nx;
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        in_flag [2];
  logic [1:0]        in_wr;
  logic [DATA_W-1:0] mem [2][FIFO_DEPTH];
  logic [AW-1:0]     wptr [2];
  logic [AW-1:0]     rptr [2];
  logic [CW-1:0]     cnt [2];
  logic [CW-1:0]     pkt_cnt [2];
  logic [1:0]        in_pkt, push, pop, drop, tail_in;
  logic              gnt, gnt_nx, last, has0, has1, pop_any, tail_out;
  logic [DATA_W-1:0] sel_beat;
  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign in_flag[0] = in0_data[DATA_W-1 -: 2];
  assign in_flag[1] = in1_data[DATA_W-1 -: 2];
  assign in_wr      = {in1_wr, in0_wr};
  // Two free entries of slack cover a source that reacts to ready one cycle late.
  assign in0_ready = (CW'(FIFO_DEPTH) - cnt[0]) >= CW'(2);
  assign in1_ready = (CW'(FIFO_DEPTH) - cnt[1]) >= CW'(2);
  // Outside a packet only a head is accepted; inside one, anything is stored until a tail.
  always_comb begin
    push    = '0;
    drop    = '0;
    tail_in = '0;
    for (int n = 0; n < 2; n++) begin
      push[n]    = in_wr[n] && (cnt[n] != CW'(FIFO_DEPTH)) && (in_pkt[n] || in_flag[n] == 2'b01);
      drop[n]    = in_wr[n] && !push[n];
      tail_in[n] = push[n] && in_pkt[n] && in_flag[n] == 2'b10;
    end
  end
  assign has0     = pkt_cnt[0] != '0;
  assign has1     = pkt_cnt[1] != '0;
  assign sel_beat = mem[gnt][rptr[gnt]];
  assign pop_any  = state == SEND && out_ready && cnt[gnt] != '0;
  assign pop      = {pop_any & gnt, pop_any & ~gnt};
  assign tail_out = pop_any && sel_beat[DATA_W-1 -: 2] == 2'b10;
  // Round-robin: with both ports holding a packet, the one not served last wins.
  always_comb begin
    state_nx = state == IDLE ? ((has0 || has1) ? SEND : IDLE) : (tail_out ? IDLE : SEND);
    gnt_nx   = state == IDLE ? ((has0 && has1) ? ~last : ~has0) : gnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk)
    for (int n = 0; n < 2; n++)
      if (push[n]) mem[n][wptr[n]] <= in_data[n];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt      <= 1'b0;
      last     <= 1'b1;
      out_wr   <= 1'b0;
      out_data <= '0;
      err_drop <= '0;
      in_pkt   <= '0;
      for (int n = 0; n < 2; n++) begin
        wptr[n]    <= '0;
        rptr[n]    <= '0;
        cnt[n]     <= '0;
        pkt_cnt[n] <= '0;
      end
    end else begin
      gnt      <= gnt_nx;
      out_wr   <= pop_any;
      err_drop <= err_drop | drop;
      if (tail_out) last <= gnt;
      if (pop_any) out_data <= sel_beat;
      for (int n = 0; n < 2; n++) begin
        wptr[n]    <= wptr[n] + AW'(push[n]);
        rptr[n]    <= rptr[n] + AW'(pop[n]);
        cnt[n]     <= cnt[n] + CW'(push[n]) - CW'(pop[n]);
        pkt_cnt[n] <= pkt_cnt[n] + CW'(tail_in[n]) - CW'(pop[n] & tail_out);
        if (push[n]) in_pkt[n] <= in_pkt[n] ? in_flag[n] != 2'b10 : 1'b1;
      end
    end
`ifdef CTL_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (tail_out && !gnt) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (tail_out && gnt)  grant_cnt1 <= grant_cnt1 + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ctl_pkt_arb.sv
// tb_ctl_pkt_arb: scoreboard bench for ctl_pkt_arb with directed packet vectors
module tb_ctl_pkt_arb;
  localparam int DATA_W = 134;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in0_data, in1_data, out_data;
  logic              in0_wr, in1_wr, in0_ready, in1_ready, out_wr, out_ready;
  logic [1:0]        err_drop;
`ifdef CTL_ARB_STATS_EN
  logic [31:0]       grant_cnt0, grant_cnt1;
`endif
  ctl_pkt_arb #(.DATA_W(DATA_W), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_wr(in0_wr), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_wr(in1_wr), .in1_ready(in1_ready),
    .out_data(out_data), .out_wr(out_wr), .out_ready(out_ready),
    .err_drop(err_drop)
`ifdef CTL_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );
  always #5 clk = ~clk;
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                out_n = 0;
  int                out_cyc [$];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_beat;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: every forwarded beat is matched against the scoreboard.
  always @(negedge clk)
    if (rst_n && out_wr) begin
      out_cyc.push_back(cyc);
      out_n++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h, required no beat", out_data);
      end else begin
        exp_beat = exp_q.pop_front();
        if (out_data !== exp_beat) begin
          errors++;
          $display("FAIL out_data: got %h, required %h", out_data, exp_beat);
        end
      end
    end
  function automatic logic [DATA_W-1:0] mk(input logic [1:0] f, input logic [31:0] p);
    return {f, {(DATA_W-34){1'b0}}, p};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask
  task automatic beat(input logic w0, input logic [DATA_W-1:0] d0,
                      input logic w1, input logic [DATA_W-1:0] d1);
    in0_wr = w0; in0_data = d0; in1_wr = w1; in1_data = d1;
    @(posedge clk);
    #1;
    in0_wr = 1'b0; in1_wr = 1'b0;
  endtask
  task automatic wait_out(input int n);
    int k = 0;
    while (out_n < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("wait_out", 64'(out_n), 64'(n));
  endtask
  int b, tc;
  logic [DATA_W-1:0] h, t, m1, m2;
  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in0_wr = 1'b0; in1_wr = 1'b0; in0_data = '0; in1_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_wr", 64'(out_wr), 0);
    chk("rst_out_data", 64'(out_data[63:0]), 0);
    chk("rst_err_drop", 64'(err_drop), 0);
    chk("rst_in0_ready", 64'(in0_ready), 1);
    chk("rst_in1_ready", 64'(in1_ready), 1);
    // Simultaneous two packets per port: grants 0,1,0,1 with a 2-cycle IDLE gap.
    b = out_n;
    exp_q.push_back(mk(2'b01, 32'hA0)); exp_q.push_back(mk(2'b10, 32'hA1));
    exp_q.push_back(mk(2'b01, 32'hC0)); exp_q.push_back(mk(2'b10, 32'hC1));
    exp_q.push_back(mk(2'b01, 32'hB0)); exp_q.push_back(mk(2'b10, 32'hB1));
    exp_q.push_back(mk(2'b01, 32'hD0)); exp_q.push_back(mk(2'b10, 32'hD1));
    beat(1, mk(2'b01, 32'hA0), 1, mk(2'b01, 32'hC0));
    beat(1, mk(2'b10, 32'hA1), 1, mk(2'b10, 32'hC1));
    tc = cyc;
    beat(1, mk(2'b01, 32'hB0), 1, mk(2'b01, 32'hD0));
    beat(1, mk(2'b10, 32'hB1), 1, mk(2'b10, 32'hD1));
    wait_out(b + 8);
    chk("sim_head_lat", 64'(out_cyc[b] - tc), 2);
    chk("sim_gap", 64'(out_cyc[b+2] - out_cyc[b+1]), 2);
    // Single 2-beat packet on port 0: head at t+2, tail at t+3.
    b = out_n;
    h = mk(2'b01, 32'h1000_0000); t = mk(2'b10, 32'h2000_0000);
    exp_q.push_back(h); exp_q.push_back(t);
    beat(1, h, 0, '0);
    beat(1, t, 0, '0);
    tc = cyc;
    wait_out(b + 2);
    chk("lat_head", 64'(out_cyc[b] - tc), 2);
    chk("lat_tail", 64'(out_cyc[b+1] - tc), 3);
    chk("lat_err_drop", 64'(err_drop), 0);
    // 4-beat port 1 packet with out_ready low for 3 cycles after beat 2.
    b = out_n;
    h = mk(2'b01, 32'h30); m1 = mk(2'b00, 32'h31); m2 = mk(2'b00, 32'h32); t = mk(2'b10, 32'h33);
    exp_q.push_back(h); exp_q.push_back(m1); exp_q.push_back(m2); exp_q.push_back(t);
    beat(0, '0, 1, h); beat(0, '0, 1, m1); beat(0, '0, 1, m2); beat(0, '0, 1, t);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_out(b + 4);
    chk("stall_gap", 64'(out_cyc[b+2] - out_cyc[b+1]), 4);
    chk("stall_resume", 64'(out_cyc[b+3] - out_cyc[b+2]), 1);
    // Overflow: 10 beats into an 8-entry FIFO while downstream is stalled.
    b = out_n;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        exp_q.push_back(mk(2'b01, 32'h400 + i));
        exp_q.push_back(mk(2'b10, 32'h410 + i));
      end
      beat(1, mk(2'b01, 32'h400 + i), 0, '0);
      beat(1, mk(2'b10, 32'h410 + i), 0, '0);
    end
    chk("ovf_err_drop", 64'(err_drop), 64'h1);
    chk("ovf_in0_ready", 64'(in0_ready), 0);
    chk("ovf_no_out", 64'(out_n), 64'(b));
    out_ready = 1'b1;
    wait_out(b + 8);
    exp_q.push_back(mk(2'b01, 32'h4F0)); exp_q.push_back(mk(2'b10, 32'h4F1));
    beat(1, mk(2'b01, 32'h4F0), 0, '0);
    beat(1, mk(2'b10, 32'h4F1), 0, '0);
    wait_out(b + 10);
    chk("ovf_err_sticky", 64'(err_drop), 64'h1);
    // Stray tail on idle port 1 is dropped and flagged.
    b = out_n;
    beat(0, '0, 1, mk(2'b10, 32'h5));
    repeat (5) @(posedge clk);
    #1;
    chk("stray_err_drop", 64'(err_drop), 64'h3);
    chk("stray_no_out", 64'(out_n), 64'(b));
    // Head inside a packet travels as a middle beat.
    b = out_n;
    exp_q.push_back(mk(2'b01, 32'h60)); exp_q.push_back(mk(2'b01, 32'h61)); exp_q.push_back(mk(2'b10, 32'h62));
    beat(1, mk(2'b01, 32'h60), 0, '0);
    beat(1, mk(2'b01, 32'h61), 0, '0);
    beat(1, mk(2'b10, 32'h62), 0, '0);
    wait_out(b + 3);
    chk("drain_pre_rst", 64'(exp_q.size()), 0);
    // Reset mid-SEND of a 4-beat packet.
    b = out_n;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(i == 0 ? 2'b01 : (i == 3 ? 2'b10 : 2'b00), 32'h70 + i));
      beat(1, mk(i == 0 ? 2'b01 : (i == 3 ? 2'b10 : 2'b00), 32'h70 + i), 0, '0);
    end
    wait_out(b + 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_mid_out_wr", 64'(out_wr), 0);
    chk("rst_mid_err_drop", 64'(err_drop), 0);
    chk("rst_mid_in0_ready", 64'(in0_ready), 1);
`ifdef CTL_ARB_STATS_EN
    chk("rst_grant_cnt0", 64'(grant_cnt0), 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b = out_n;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_no_stale", 64'(out_n), 64'(b));
    exp_q.push_back(mk(2'b01, 32'h80)); exp_q.push_back(mk(2'b10, 32'h81));
    beat(1, mk(2'b01, 32'h80), 0, '0);
    beat(1, mk(2'b10, 32'h81), 0, '0);
    wait_out(b + 2);
`ifdef CTL_ARB_STATS_EN
    chk("post_grant_cnt0", 64'(grant_cnt0), 1);
    chk("post_grant_cnt1", 64'(grant_cnt1), 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("drain_final", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1);
  end
endmodule
